rr_arbiter: RTL

N-channel clocked mutual-exclusion arbiter, successor to the two-input asynchronous ME element. Grants at most one of `N` requesters at a time with round-robin fairness, holds a grant for as long as the owner keeps requesting, and optionally preempts a long-held grant when others are waiting. Sits between shared-resource clients and the resource, and replaces pairwise ME cells wherever more than two clients or a clocked handshake are needed.

---
 rtl/rr_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-channel clocked mutual-exclusion arbiter.
// Grants at most one requester at a time in round-robin order, keeps the
// grant while the owner holds its request, optionally revokes a grant held
// too long under contention, and always leaves one empty cycle between
// consecutive owners so the grant vector never shows two owners back to back.

module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            preempt
);

    localparam int         SW        = ID_W + 1;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [7:0]      hold_cnt;

    logic [N-1:0]    rot_req;
    logic [SW-1:0]   cand;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic            owner_req;
    logic            others_req;
    logic            timeout;
    logic [ID_W-1:0] next_ptr;

    // Rotate requests so bit 0 is the channel at ptr, then take the first set bit and map it back to a channel index.
    always_comb begin
        rot_req    = N'({req, req} >> ptr);
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_valid && rot_req[i]) begin
                pick_valid = 1'b1;
                cand       = {1'b0, ptr} + SW'(i);
                if (cand >= SW'(N)) begin
                    cand = cand - SW'(N);
                end
                pick_id = cand[ID_W-1:0];
            end
        end
    end

    // Owner/contention status and the lowest-priority pointer for the current owner.
    always_comb begin
        owner_req  = |(req & grant);
        others_req = |(req & ~grant);
        timeout    = (MAX_HOLD > 0) && (hold_cnt == HOLD_LIMIT) && others_req;
        next_ptr   = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            preempt     <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    preempt <= 1'b0;
                    if (pick_valid) begin
                        grant       <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        hold_cnt    <= 8'd1;
                        state       <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req || timeout) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                        preempt     <= owner_req;
                        state       <= GAP;
                    end else begin
                        preempt <= 1'b0;
                        if (hold_cnt < HOLD_LIMIT) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    preempt     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
